clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen.sv | 115 +++++++++++
 tb/tb_clk_en_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_gen
// Brief    : Multi-channel fractional (num/den) clock-enable generator with
//            runtime reconfiguration and a settle-time lock indicator.
// Revision : 1.0 - initial release
// ============================================================================
module clk_en_gen #(
  parameter int                        CHANNELS    = 3,
  parameter int                        ACC_W       = 16,
  parameter int                        LOCK_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0] DEF_NUM     = {16'd1, 16'd1, 16'd1},
  parameter logic [CHANNELS*ACC_W-1:0] DEF_DEN     = {16'd2, 16'd8, 16'd1}
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] ce,
  output logic                cfg_err,
  output logic                locked
);

  localparam int                  c_LCNT_W    = 16;
  localparam logic [c_LCNT_W-1:0] c_LOCK_LAST = c_LCNT_W'(LOCK_CYCLES - 1);

  logic w_wr_bad;
  logic w_wr_valid;

  always_comb begin
    w_wr_bad   = (int'(cfg_ch) >= CHANNELS) || (cfg_den == '0) || (cfg_num > cfg_den);
    w_wr_valid = cfg_we && !w_wr_bad;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Reset defaults are listed channel 0 first, i.e. channel 0 sits in the MSB slice.
    localparam logic [ACC_W-1:0] c_RST_NUM = DEF_NUM[ACC_W*(CHANNELS-1-i) +: ACC_W];
    localparam logic [ACC_W-1:0] c_RST_DEN = DEF_DEN[ACC_W*(CHANNELS-1-i) +: ACC_W];

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_num;
    logic [ACC_W-1:0] r_den;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_wrap;
    logic             w_hit;
    logic             w_sel;

    always_comb begin
      w_sum  = {1'b0, r_acc} + {1'b0, r_num};
      // acc < den and num <= den keep the wrapped result below den, so modular math is exact.
      w_wrap = w_sum[ACC_W-1:0] - r_den;
      w_hit  = (w_sum >= {1'b0, r_den});
      w_sel  = w_wr_valid && (cfg_ch == 3'(i));
    end

    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        r_acc <= '0;
        r_num <= c_RST_NUM;
        r_den <= c_RST_DEN;
        r_ce  <= 1'b0;
      end else if (w_sel) begin
        r_num <= cfg_num;
        r_den <= cfg_den;
        r_acc <= '0;
        r_ce  <= 1'b0;
      end else if (ch_en[i]) begin
        if (w_hit) begin
          r_acc <= w_wrap;
          r_ce  <= 1'b1;
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
          r_ce  <= 1'b0;
        end
      end else begin
        r_ce <= 1'b0;
      end
    end

    assign ce[i] = r_ce;
  end

  logic [c_LCNT_W-1:0] r_lock_cnt;
  logic                r_locked;
  logic                r_cfg_err;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && w_wr_bad;
      if (w_wr_valid) begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end else if (!r_locked) begin
        if (r_lock_cnt == c_LOCK_LAST) begin
          r_locked <= 1'b1;
        end else begin
          r_lock_cnt <= r_lock_cnt + c_LCNT_W'(1);
        end
      end
    end
  end

  assign cfg_err = r_cfg_err;
  assign locked  = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_en_gen
// Brief    : Directed bench for clk_en_gen against a rate-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_en_gen;

  localparam int CH   = 3;
  localparam int AW   = 16;
  localparam int LOCK = 1024;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [2:0]    cfg_ch;
  logic [AW-1:0] cfg_num;
  logic [AW-1:0] cfg_den;
  logic [CH-1:0] ch_en;
  wire  [CH-1:0] ce;
  wire           cfg_err;
  wire           locked;

  always #5 refclk = ~refclk;

  clk_en_gen #(
    .CHANNELS   (CH),
    .ACC_W      (AW),
    .LOCK_CYCLES(LOCK),
    .DEF_NUM    ({16'd1, 16'd1, 16'd1}),
    .DEF_DEN    ({16'd2, 16'd8, 16'd1})
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_num(cfg_num),
    .cfg_den(cfg_den),
    .ch_en  (ch_en),
    .ce     (ce),
    .cfg_err(cfg_err),
    .locked (locked)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: actual=timeout required=event at %0t", name, $time);
  endtask

  // Reference model: a channel whose k-th enabled step since its last clear
  // pulses exactly when floor(k*num/den) advances.
  longint m_num[CH];
  longint m_den[CH];
  longint m_k[CH];
  bit     m_ce[CH];
  bit     m_err;
  bit     m_locked;
  int     m_since;

  function automatic longint def_den(input int ch);
    case (ch)
      0:       return 2;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  always @(posedge refclk) begin : model
    bit valid;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_num[i] = 1;
        m_den[i] = def_den(i);
        m_k[i]   = 0;
        m_ce[i]  = 1'b0;
      end
      m_err    = 1'b0;
      m_since  = 0;
      m_locked = 1'b0;
    end else begin
      valid = cfg_we && (int'(cfg_ch) < CH) && (cfg_den != 0) && (cfg_num <= cfg_den);
      m_err = cfg_we && !valid;
      for (int i = 0; i < CH; i++) begin
        if (valid && int'(cfg_ch) == i) begin
          m_num[i] = longint'(cfg_num);
          m_den[i] = longint'(cfg_den);
          m_k[i]   = 0;
          m_ce[i]  = 1'b0;
        end else if (ch_en[i]) begin
          m_k[i]++;
          m_ce[i] = ((m_k[i] * m_num[i]) / m_den[i]) != (((m_k[i] - 1) * m_num[i]) / m_den[i]);
        end else begin
          m_ce[i] = 1'b0;
        end
      end
      if (valid) m_since = 0;
      else if (m_since < LOCK) m_since++;
      m_locked = (m_since >= LOCK);
    end
  end

  always @(negedge refclk) begin
    if (chk_on) begin
      for (int i = 0; i < CH; i++) chk($sformatf("model_ce%0d", i), ce[i], m_ce[i]);
      chk("model_cfg_err", cfg_err, m_err);
      chk("model_locked", locked, m_locked);
    end
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [AW-1:0] n, input logic [AW-1:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_num = n;
    cfg_den = d;
    step();
    cfg_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    int          ones;
    int          w;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0; ch_en = '1;
    repeat (3) step();
    chk("rst_ce", ce, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_locked", locked, 0);
    chk_on = 1'b1;

    // Default rates and lock time
    rst_n = 1'b1;
    for (int e = 1; e <= LOCK + 4; e++) begin
      step();
      if (e <= 24) begin
        chk("def_ce0", ce[0], (e % 2) == 0);
        chk("def_ce1", ce[1], (e % 8) == 0);
        chk("def_ce2", ce[2], 1);
      end
      if (e == LOCK - 1) chk("lock_early", locked, 0);
      if (e == LOCK)     chk("lock_rise", locked, 1);
    end

    // 3/8 on channel 0
    wr(3'd0, 16'd3, 16'd8);
    chk("wr_locked_drop", locked, 0);
    chk("wr_ce0_clear", ce[0], 0);
    pat = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      pat[k] = ce[0];
    end
    chk("frac_period1", pat[7:0], 8'hA4);
    chk("frac_period2", pat[15:8], 8'hA4);
    chk("frac_count", $countones(pat[7:0]), 3);
    chk("frac_adjacent", pat & (pat >> 1), 0);
    for (int e = 17; e <= LOCK + 2; e++) begin
      step();
      if (e == LOCK - 1) chk("relock_early", locked, 0);
      if (e == LOCK)     chk("relock_rise", locked, 1);
    end

    // Rejected writes
    wr(3'd0, 16'd3, 16'd0);
    chk("bad_den0_err", cfg_err, 1);
    chk("bad_den0_locked", locked, 1);
    step();
    chk("bad_den0_err_end", cfg_err, 0);
    wr(3'd0, 16'd9, 16'd8);
    chk("bad_ratio_err", cfg_err, 1);
    chk("bad_ratio_locked", locked, 1);
    step();
    wr(3'd5, 16'd1, 16'd2);
    chk("bad_ch_err", cfg_err, 1);
    chk("bad_ch_locked", locked, 1);
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      ones += int'(ce[0]);
    end
    chk("bad_cfg_kept_rate", ones, 3);

    // Write channel 1 exactly on its scheduled overflow
    w = 0;
    while ((m_k[1] % 8) != 7 && w < 16) begin
      step();
      w++;
    end
    if ((m_k[1] % 8) != 7) fail_now("ovf_wait");
    wr(3'd1, 16'd1, 16'd8);
    chk("ovf_wr_no_pulse", ce[1], 0);
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("ovf_next_pulse", ce[1], e == 8);
    end

    // Pause channel 1 at acc=4
    for (int e = 1; e <= 4; e++) step();
    ch_en[1] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("pause_ce1_low", ce[1], 0);
    end
    ch_en[1] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("resume_ce1", ce[1], e == 4);
    end

    // Reset together with a write
    rst_n = 1'b0;
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_num = 16'd1; cfg_den = 16'd1;
    step();
    cfg_we = 1'b0;
    rst_n  = 1'b1;
    chk("midrst_ce", ce, 0);
    chk("midrst_cfg_err", cfg_err, 0);
    chk("midrst_locked", locked, 0);
    for (int e = 1; e <= 16; e++) begin
      step();
      chk("midrst_ce0", ce[0], (e % 2) == 0);
      chk("midrst_ce1", ce[1], (e % 8) == 0);
      chk("midrst_ce2", ce[2], 1);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
